// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request arbiter.
package dma_pkg;

   localparam int unsigned DMA_ADDR_W    = 21;
   localparam int unsigned DMA_TAG_DEPTH = 2;

   typedef logic [1:0] dma_id_t;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/dma_arbiter_if.sv
// Requester-side and dma_access-side signals of the DMA arbiter.
interface dma_arbiter_if
   import dma_pkg::*;
#(
   parameter int unsigned NREQ   = 3,
   parameter int unsigned ADDR_W = DMA_ADDR_W
);

   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        req_rnw;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*8-1:0]      req_wd;
   logic [NREQ-1:0]        req_ack;
   logic [NREQ-1:0]        req_end;
   logic [7:0]             req_rd;

   logic                   dma_req;
   logic                   dma_rnw;
   logic [ADDR_W-1:0]      dma_addr;
   logic [7:0]             dma_wd;
   logic                   dma_ack;
   logic                   dma_end;
   logic [7:0]             dma_rd;

   logic                   busy;
   logic                   err_orphan;

   // Arbiter view.
   modport slave (
      input  req, req_rnw, req_addr, req_wd, dma_ack, dma_end, dma_rd,
      output req_ack, req_end, req_rd, dma_req, dma_rnw, dma_addr, dma_wd,
             busy, err_orphan
   );

   // Environment view: requesters plus dma_access.
   modport master (
      output req, req_rnw, req_addr, req_wd, dma_ack, dma_end, dma_rd,
      input  req_ack, req_end, req_rd, dma_req, dma_rnw, dma_addr, dma_wd,
             busy, err_orphan
   );

endinterface

// File: rtl/dma_tag_fifo.sv
// Small FIFO of requester ids, one per acked but not yet ended transfer.
module dma_tag_fifo
   import dma_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push_i,
   input  logic    pop_i,
   input  dma_id_t din_i,
   output dma_id_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int unsigned PTR_W = (DMA_TAG_DEPTH > 1) ? $clog2(DMA_TAG_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DMA_TAG_DEPTH + 1);

   dma_id_t          mem_q [DMA_TAG_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DMA_TAG_DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   // Storage, pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DMA_TAG_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DMA_TAG_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DMA_TAG_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one dma_access engine between several requesters.
module dma_arbiter
   import dma_pkg::*;
#(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned ADDR_W    = DMA_ADDR_W
)(
   input  logic          clk,
   input  logic          rst_n,
   dma_arbiter_if.slave  bus
);

   arb_state_t        state_q, state_d;
   dma_id_t           grant_id_q, grant_id_d;
   dma_id_t           last_id_q, last_id_d;
   logic [7:0]        burst_cnt_q, burst_cnt_d;
   logic              err_orphan_q, err_orphan_d;

   logic              grant_valid;
   logic [NREQ-1:0]   sel;
   logic              owner_req;
   logic              dma_req_c;
   logic              ack_ok;
   logic              end_ok;
   logic [2:0]        pick;
   dma_id_t           tag_head;
   logic              tag_full;
   logic              tag_empty;
   logic [ADDR_W-1:0] addr_acc [NREQ+1];
   logic [7:0]        wd_acc   [NREQ+1];

   // Next requester after 'last' with req high, wrapping; bit 2 flags a find.
   function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input dma_id_t last);
      logic [3:0]  r4;
      logic [2:0]  res;
      dma_id_t     idx;
      r4  = 4'(r);
      res = '0;
      for (int unsigned k = NREQ; k >= 1; k--) begin
         idx = dma_id_t'((32'(last) + k) % NREQ);
         if (r4[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign grant_valid = (state_q == ARB_GRANT);
   assign pick        = rr_pick(bus.req, last_id_q);

   // One-hot select of the granted requester and AND-OR mux of its payload.
   assign addr_acc[0] = '0;
   assign wd_acc[0]   = '0;
   for (genvar g = 0; g < NREQ; g++) begin : g_sel
      assign sel[g]        = grant_valid & (grant_id_q == dma_id_t'(g));
      assign addr_acc[g+1] = addr_acc[g] | (sel[g] ? bus.req_addr[g*ADDR_W +: ADDR_W] : '0);
      assign wd_acc[g+1]   = wd_acc[g]   | (sel[g] ? bus.req_wd[g*8 +: 8] : 8'h00);
   end

   assign owner_req = |(sel & bus.req);
   assign dma_req_c = owner_req & ~tag_full;
   assign ack_ok    = bus.dma_ack & dma_req_c;
   assign end_ok    = bus.dma_end & ~tag_empty;

   assign bus.dma_req    = dma_req_c;
   assign bus.dma_rnw    = |(sel & bus.req_rnw);
   assign bus.dma_addr   = addr_acc[NREQ];
   assign bus.dma_wd     = wd_acc[NREQ];
   assign bus.req_ack    = ack_ok ? (NREQ'(1) << grant_id_q) : '0;
   assign bus.req_end    = end_ok ? (NREQ'(1) << tag_head) : '0;
   assign bus.req_rd     = bus.dma_rd;
   assign bus.busy       = grant_valid | ~tag_empty;
   assign bus.err_orphan = err_orphan_q;

   dma_tag_fifo u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ack_ok),
      .pop_i   (end_ok),
      .din_i   (grant_id_q),
      .head_o  (tag_head),
      .full_o  (tag_full),
      .empty_o (tag_empty)
   );

   // Grant state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         grant_id_q   <= '0;
         last_id_q    <= dma_id_t'(NREQ - 1);
         burst_cnt_q  <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_id_q    <= last_id_d;
         burst_cnt_q  <= burst_cnt_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   // Arbitration, burst counting and release.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_id_d    = last_id_q;
      burst_cnt_d  = burst_cnt_q;
      err_orphan_d = err_orphan_q | (bus.dma_end & tag_empty);
      case (state_q)
         ARB_IDLE: begin
            if (pick[2]) begin
               state_d     = ARB_GRANT;
               grant_id_d  = pick[1:0];
               last_id_d   = pick[1:0];
               burst_cnt_d = '0;
            end
         end
         ARB_GRANT: begin
            if (ack_ok) burst_cnt_d = burst_cnt_q + 8'd1;
            if ((ack_ok && (burst_cnt_q == 8'(MAX_BURST - 1))) ||
                (!owner_req && !bus.dma_ack)) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dma_arbiter.sv
// Self-checking bench for dma_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_dma_arbiter;

   localparam int unsigned NREQ = 3;
   localparam int unsigned AW   = 21;
   localparam int          MB0  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dma_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW)) bus0 ();
   dma_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW)) bus1 ();

   dma_arbiter #(.NREQ(NREQ), .MAX_BURST(MB0), .ADDR_W(AW)) u_dut (
      .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
   );

   dma_arbiter #(.NREQ(NREQ), .MAX_BURST(1), .ADDR_W(AW)) u_dut_b1 (
      .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int   m_gv, m_gid, m_last, m_cnt;
   logic m_err;
   int   m_tags [$];

   // Samples of the last cycle and model expectations.
   logic [2:0]  o_ack, o_end;
   logic [7:0]  o_rd, o_wd;
   logic        o_dreq, o_rnw, o_busy, o_err;
   logic [20:0] o_addr;
   logic [46:0] o_vec, e_vec;

   task automatic model_reset();
      m_gv = 0; m_gid = 0; m_last = NREQ - 1; m_cnt = 0; m_err = 1'b0;
      m_tags.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus0.req = '0; bus0.req_rnw = '0; bus0.req_addr = '0; bus0.req_wd = '0;
      bus0.dma_ack = 1'b0; bus0.dma_end = 1'b0; bus0.dma_rd = '0;
      bus1.req = '0; bus1.req_rnw = '0; bus1.req_addr = '0; bus1.req_wd = '0;
      bus1.dma_ack = 1'b0; bus1.dma_end = 1'b0; bus1.dma_rd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   // One clock of bus0: drive, sample at negedge, advance the model.
   task automatic cycle(input logic [2:0] r, input logic [2:0] rnw, input logic [62:0] addr,
                        input logic [23:0] wd, input logic ack, input logic ack_auto,
                        input logic dend, input logic [7:0] rd);
      logic       req_g, full, ack_ok, rel, found;
      logic [2:0] e_ack, e_end;
      logic [20:0] e_addr;
      logic [7:0] e_wd;
      logic       e_dreq, e_rnw, e_busy;
      int         id;
      bus0.req = r; bus0.req_rnw = rnw; bus0.req_addr = addr; bus0.req_wd = wd;
      bus0.dma_ack = ack; bus0.dma_end = dend; bus0.dma_rd = rd;
      #1;
      if (ack_auto) bus0.dma_ack = bus0.dma_req;
      @(negedge clk);
      o_ack = bus0.req_ack; o_end = bus0.req_end; o_rd = bus0.req_rd;
      o_dreq = bus0.dma_req; o_rnw = bus0.dma_rnw; o_addr = bus0.dma_addr;
      o_wd = bus0.dma_wd; o_busy = bus0.busy; o_err = bus0.err_orphan;
      o_vec = {o_ack, o_end, o_rd, o_dreq, o_rnw, o_addr, o_wd, o_busy, o_err};
      // expected outputs from the rules
      req_g  = (m_gv != 0) && r[m_gid];
      full   = (m_tags.size() >= 2);
      e_dreq = req_g && !full;
      e_addr = '0; e_rnw = 1'b0; e_wd = '0;
      if (m_gv != 0) begin
         e_addr = addr[m_gid*21 +: 21];
         e_rnw  = rnw[m_gid];
         e_wd   = wd[m_gid*8 +: 8];
      end
      ack_ok = bus0.dma_ack && e_dreq;
      e_ack  = ack_ok ? 3'(1 << m_gid) : 3'b000;
      e_end  = (dend && m_tags.size() > 0) ? 3'(1 << m_tags[0]) : 3'b000;
      e_busy = (m_gv != 0) || (m_tags.size() > 0);
      e_vec  = {e_ack, e_end, rd, e_dreq, e_rnw, e_addr, e_wd, e_busy, m_err};
      // next model state
      if (dend) begin
         if (m_tags.size() > 0) void'(m_tags.pop_front());
         else m_err = 1'b1;
      end
      if (m_gv == 0) begin
         found = 1'b0;
         for (int k = 1; k <= int'(NREQ); k++) begin
            id = (m_last + k) % NREQ;
            if (!found && r[id]) begin
               found = 1'b1; m_gv = 1; m_gid = id; m_last = id; m_cnt = 0;
            end
         end
      end else begin
         rel = (ack_ok && m_cnt == MB0 - 1) || (!r[m_gid] && !bus0.dma_ack);
         if (ack_ok) begin
            m_tags.push_back(m_gid);
            m_cnt++;
         end
         if (rel) m_gv = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus0.dma_req, bus0.dma_rnw, bus0.dma_addr, bus0.dma_wd, bus0.req_ack,
           bus0.req_end, bus0.busy, bus0.err_orphan} !== 37'd0) begin
         $display("FAIL reset_outputs: got req=%b rnw=%b addr=%h wd=%h ack=%b end=%b busy=%b err=%b, expected all 0",
                  bus0.dma_req, bus0.dma_rnw, bus0.dma_addr, bus0.dma_wd, bus0.req_ack,
                  bus0.req_end, bus0.busy, bus0.err_orphan);
      end else n_pass++;
      cycle(3'b000, '0, '0, '0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (o_ack !== 3'b000) $display("FAIL stray_ack: req_ack=%b expected 000", o_ack);
      else n_pass++;
      cycle(3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL stray_ack_push: busy=%b expected 0", o_busy);
      else n_pass++;
   endtask

   task automatic test_single_read();
      logic [62:0] a;
      do_reset();
      a = 63'h12345;
      cycle(3'b001, 3'b001, a, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (o_dreq !== 1'b0) $display("FAIL read_arb_cycle: dma_req=%b expected 0", o_dreq);
      else n_pass++;
      cycle(3'b001, 3'b001, a, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({o_dreq, o_rnw, o_addr} !== {1'b1, 1'b1, 21'h12345})
         $display("FAIL read_fwd: dma_req=%b rnw=%b addr=%h expected 1 1 12345", o_dreq, o_rnw, o_addr);
      else n_pass++;
      cycle(3'b001, 3'b001, a, '0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (o_ack !== 3'b001) $display("FAIL read_ack: req_ack=%b expected 001", o_ack);
      else n_pass++;
      cycle(3'b000, 3'b000, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({o_ack, o_busy} !== 4'b0001) $display("FAIL read_wait: req_ack=%b busy=%b expected 000 1", o_ack, o_busy);
      else n_pass++;
      cycle(3'b000, 3'b000, '0, '0, 1'b0, 1'b0, 1'b1, 8'hA5);
      n_checks++;
      if ({o_end, o_rd} !== {3'b001, 8'hA5}) $display("FAIL read_end: req_end=%b rd=%h expected 001 a5", o_end, o_rd);
      else n_pass++;
      cycle(3'b000, 3'b000, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL read_idle: busy=%b expected 0", o_busy);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic       exp_dreq [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0] exp_ack  [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      logic [2:0] exp_end  [8] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
      logic       pend;
      do_reset();
      pend = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus1.req = 3'b111; bus1.dma_end = pend; bus1.dma_ack = 1'b0;
         #1;
         bus1.dma_ack = bus1.dma_req;
         @(negedge clk);
         n_checks++;
         if ({bus1.dma_req, bus1.req_ack, bus1.req_end} !== {exp_dreq[c], exp_ack[c], exp_end[c]})
            $display("FAIL rr_cycle%0d: dma_req=%b ack=%b end=%b expected %b %b %b", c,
                     bus1.dma_req, bus1.req_ack, bus1.req_end, exp_dreq[c], exp_ack[c], exp_end[c]);
         else n_pass++;
         pend = bus1.dma_ack & bus1.dma_req;
         @(posedge clk);
         #1;
      end
      bus1.req = '0; bus1.dma_ack = 1'b0; bus1.dma_end = 1'b0;
   endtask

   task automatic test_burst_limit();
      logic exp_dreq [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int   acks;
      do_reset();
      acks = 0;
      for (int c = 0; c < 7; c++) begin
         cycle(3'b010, '0, '0, '0, 1'b0, (c > 0), (c >= 2), 8'h00);
         if (o_ack == 3'b010 && c < 6) acks++;
         n_checks++;
         if (o_dreq !== exp_dreq[c]) $display("FAIL burst_dreq%0d: dma_req=%b expected %b", c, o_dreq, exp_dreq[c]);
         else n_pass++;
      end
      n_checks++;
      if (acks !== MB0) $display("FAIL burst_ack_count: acks=%0d expected %0d", acks, MB0);
      else n_pass++;
      n_checks++;
      if (o_ack !== 3'b010) $display("FAIL burst_regrant: req_ack=%b expected 010", o_ack);
      else n_pass++;
   endtask

   task automatic test_pipelined_ends();
      do_reset();
      cycle(3'b100, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(3'b100, '0, '0, '0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (o_ack !== 3'b100) $display("FAIL pipe_ack1: req_ack=%b expected 100", o_ack);
      else n_pass++;
      cycle(3'b100, '0, '0, '0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (o_ack !== 3'b100) $display("FAIL pipe_ack2: req_ack=%b expected 100", o_ack);
      else n_pass++;
      cycle(3'b100, '0, '0, '0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({o_dreq, o_ack} !== 4'b0000) $display("FAIL pipe_full_block: dma_req=%b ack=%b expected 0 000", o_dreq, o_ack);
      else n_pass++;
      cycle(3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(3'b001, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(3'b001, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h3C);
      n_checks++;
      if ({o_end, o_dreq} !== 4'b1000) $display("FAIL pipe_end1: req_end=%b dma_req=%b expected 100 0", o_end, o_dreq);
      else n_pass++;
      cycle(3'b001, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'hC3);
      n_checks++;
      if ({o_end, o_dreq} !== 4'b1001) $display("FAIL pipe_end2: req_end=%b dma_req=%b expected 100 1", o_end, o_dreq);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      cycle(3'b010, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(3'b010, '0, '0, '0, 1'b0, 1'b1, 1'b0, 8'h00);
      cycle(3'b001, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(3'b001, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(3'b001, '0, '0, '0, 1'b0, 1'b1, 1'b1, 8'h5A);
      n_checks++;
      if ({o_ack, o_end} !== 6'b001_010) $display("FAIL simul_strobes: ack=%b end=%b expected 001 010", o_ack, o_end);
      else n_pass++;
      cycle(3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (o_end !== 3'b001) $display("FAIL simul_second_end: req_end=%b expected 001", o_end);
      else n_pass++;
      cycle(3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({o_busy, o_err} !== 2'b00) $display("FAIL simul_drained: busy=%b err=%b expected 0 0", o_busy, o_err);
      else n_pass++;
   endtask

   task automatic test_orphan_and_reset();
      do_reset();
      cycle(3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if ({o_end, o_err} !== 4'b0000) $display("FAIL orphan_end: req_end=%b err=%b expected 000 0", o_end, o_err);
      else n_pass++;
      cycle(3'b000, '0, '0, '0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({o_err, o_busy} !== 2'b10) $display("FAIL orphan_sticky: err=%b busy=%b expected 1 0", o_err, o_busy);
      else n_pass++;
      cycle(3'b001, 3'b001, 63'h1FFFFF, 24'h0000FF, 1'b0, 1'b0, 1'b0, 8'h00);
      cycle(3'b001, 3'b001, 63'h1FFFFF, 24'h0000FF, 1'b0, 1'b1, 1'b0, 8'h00);
      bus0.dma_ack = 1'b1; bus0.dma_end = 1'b1; bus0.dma_rd = 8'h00;
      #1;
      n_checks++;
      if ({bus0.dma_req, bus0.req_ack, bus0.busy} !== 5'b1_001_1)
         $display("FAIL midreset_pre: dma_req=%b ack=%b busy=%b expected 1 001 1", bus0.dma_req, bus0.req_ack, bus0.busy);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus0.dma_req, bus0.dma_rnw, bus0.dma_addr, bus0.dma_wd, bus0.req_ack,
           bus0.req_end, bus0.req_rd, bus0.busy, bus0.err_orphan} !== 45'd0)
         $display("FAIL midreset_outputs: req=%b rnw=%b addr=%h wd=%h ack=%b end=%b busy=%b err=%b expected all 0",
                  bus0.dma_req, bus0.dma_rnw, bus0.dma_addr, bus0.dma_wd, bus0.req_ack,
                  bus0.req_end, bus0.busy, bus0.err_orphan);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_random();
      logic [2:0]  r_cur;
      logic [2:0]  rnw;
      logic [62:0] addr;
      logic [23:0] wd;
      do_reset();
      r_cur = '0;
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 3; b++) if ($urandom_range(3) == 0) r_cur[b] = ~r_cur[b];
         rnw  = 3'($urandom);
         addr = 63'({$urandom(), $urandom()});
         wd   = 24'($urandom);
         cycle(r_cur, rnw, addr, wd, ($urandom_range(1) == 1), 1'b0,
               ($urandom_range(3) == 0), 8'($urandom));
         n_checks++;
         if (o_vec !== e_vec)
            $display("FAIL random_cycle%0d: outputs=%h expected %h", c, o_vec, e_vec);
         else n_pass++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_burst_limit();
      test_pipelined_ends();
      test_simultaneous();
      test_orphan_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Round-robin arbiter that shares the single `dma_access` bus-takeover engine between up to four DMA requesters (ZX-bus DMA, SD-card DMA, MP3 feeder DMA, spare). It sits between the requester modules and `dma_access` in the `main` top level. It forwards one requester's address, direction and write data, routes `dma_ack`/`dma_end`/`dma_rd` back to the owner of each transfer, and bounds each grant to a programmable burst length.

## Interface
- `NREQ`, default 3: number of requesters, legal range 2..4.
- `MAX_BURST`, default 16: maximum acked transfers per grant, legal range 1..256.
- `ADDR_W`, default 21: DMA address width.
- `clk` input 1: single clock, the Z80/FPGA clock domain.
- `rst_n` input 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req` input NREQ: per-requester transfer request, level.
- `req_rnw` input NREQ: per-requester direction; 1 = read.
- `req_addr` input NREQ*ADDR_W: per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_wd` input NREQ*8: per-requester write data; requester i occupies bits [i*8 +: 8].
- `req_ack` output NREQ: per-requester acceptance strobe, one cycle.
- `req_end` output NREQ: per-requester completion strobe, one cycle.
- `req_rd` output 8: read data, broadcast to all requesters; valid only when qualified by that requester's `req_end`.
- `dma_req` output 1: request to `dma_access`.
- `dma_rnw` output 1: direction to `dma_access`.
- `dma_addr` output ADDR_W: address to `dma_access`.
- `dma_wd` output 8: write data to `dma_access`.
- `dma_ack` input 1: `dma_access` has latched addr/rnw/wd; a one-cycle pulse.
- `dma_end` input 1: `dma_access` transfer complete; `dma_rd` is valid this cycle for reads.
- `dma_rd` input 8: read data from `dma_access`.
- `busy` output 1: a grant is held or the tag FIFO is non-empty.
- `err_orphan` output 1: sticky; set when `dma_end` arrives with the tag FIFO empty.

## Operation
- State is held in registers: `grant_valid`, `grant_id[1:0]`, `last_id[1:0]`, `burst_cnt[7:0]`, a 2-entry tag FIFO of requester ids, and `err_orphan`.
- **Arbitration.**
  - Performed only when `grant_valid` = 0 and at least one `req` is high.
  - Search order starts at `(last_id+1) mod NREQ` and wraps.
  - The first requester found is granted: `grant_valid`←1, `grant_id`←winner, `last_id`←winner, `burst_cnt`←0.
- **Forwarding.**
  - `dma_req` = `grant_valid & req[grant_id] & !tag_full`.
  - `dma_rnw`, `dma_addr` and `dma_wd` are a combinational mux of the granted requester's inputs. They are all-zero when `grant_valid` = 0.
- **Acceptance.**
  - `req_ack[grant_id]` = `dma_ack`, combinational, same cycle.
  - On `dma_ack`, `grant_id` is pushed into the tag FIFO and `burst_cnt` increments.
  - A requester that wants to continue keeps `req` high and presents its next address in the cycle after the ack.
- **Release.** `grant_valid`←0 at the end of a cycle in which either condition holds:
  - (a) `dma_ack` and `burst_cnt` = MAX_BURST-1; or
  - (b) `grant_valid` and `req[grant_id]` = 0 and no `dma_ack`.
- **Completion.**
  - On `dma_end` the FIFO head is popped, and `req_end[head]` pulses in the same cycle.
  - `req_rd` = `dma_rd`, combinational.
- **Simultaneous `dma_ack` and `dma_end`.** Push and pop happen in the same cycle; the occupancy is unchanged.
- **FIFO full** (2 outstanding transfers): `dma_req` is held low until a `dma_end` pops an entry.
- **Orphan end** (`dma_end` with the FIFO empty): no `req_end` pulses, `err_orphan`←1, and the FIFO is unchanged. `err_orphan` clears only on reset.
- **`dma_ack` without `dma_req`:** ignored; nothing is pushed and no ack is routed.

## Timing
- Reset values:
  - registers: `grant_valid` 0, `last_id` NREQ-1 (so requester 0 wins first), FIFO empty, `burst_cnt` 0, `err_orphan` 0;
  - hence outputs: `dma_req` 0, `dma_addr`/`dma_rnw`/`dma_wd` 0, `req_ack` 0, `req_end` 0, `busy` 0.
- Request latency: `req` rising at edge N, with the arbiter idle, gives `dma_req` high from edge N+1.
- Hand-over between different requesters: `dma_req` is low for exactly one cycle, the arbitration cycle.
- Same requester continuing within its burst: `dma_req` is not dropped between transfers.
- Ack and end routing are zero-latency, combinational from the `dma_*` inputs.
- Reset asserted mid-transfer: all state clears immediately. Requesters and `dma_access` share `rst_n`, so no outstanding transfer survives.

## Structure
- Shared package `dma_pkg` holds `DMA_ADDR_W` = 21, `DMA_TAG_DEPTH` = 2 and the `dma_id_t` 2-bit id type.
- One natural sub-module, `dma_tag_fifo`: 2-deep, 2-bit wide, with simultaneous push/pop, `full` and `empty` outputs.
- Round-robin selection is a function inside `dma_arbiter`.

## Test plan
- **Reset, then a single read:** `req[0]`, addr 0x12345, rnw 1; `dma_ack` at +2, `dma_end` with `dma_rd`=0xA5 at +4 → `req_ack[0]` at +2, `req_end[0]` with `req_rd`=0xA5 at +4, `busy` 0 afterwards.
- **Round-robin:** `req[0]`, `req[1]` and `req[2]` held high, MAX_BURST=1 → grants 0,1,2,0 in order, with one idle `dma_req` cycle between grants.
- **Burst limit:** `req[1]` held high, MAX_BURST=4 → exactly 4 acks, then `dma_req` low for one cycle, then `req[1]` is regranted (sole requester).
- **Pipelined ends:** two acks for requester 2, then the ends of requesters 2 and 2 arrive while a grant to requester 0 is active → ends are routed to requester 2 twice. A third ack is blocked (`dma_req` 0) while the FIFO is full.
- **Simultaneous `dma_ack` and `dma_end`** in one cycle → FIFO occupancy stays at 1, and both strobes go to the correct requesters.
- **Orphan `dma_end` after reset** → `err_orphan`=1 and no `req_end` pulses. Reset asserted mid-burst → all outputs are 0 in the same cycle.
